// File: rtl/netfpga_sume_10g_pkg.sv
// Shared types for the 10GbE RX packet FIFO: AXI-Stream widths, FIFO word layout
// and the write-side FSM states.
package netfpga_sume_10g_pkg;

  localparam int AXIS_DATA_W = 64;
  localparam int AXIS_KEEP_W = 8;

  typedef struct packed {
    logic                   tlast;
    logic [AXIS_KEEP_W-1:0] tkeep;
    logic [AXIS_DATA_W-1:0] tdata;
  } fifo_word_t;

  localparam int FIFO_WORD_W = $bits(fifo_word_t);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DROP  = 2'd2
  } wr_state_e;

endpackage

// File: rtl/netfpga_sume_sdp_ram.sv
// Simple dual-port RAM with one write port and a registered read port,
// written so synthesis maps it onto block RAM.
module netfpga_sume_sdp_ram #(
  parameter int WIDTH = 73,
  parameter int DEPTH = 512,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // The read register only updates on a read, so the output holds while stalled.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/netfpga_sume_10g_rx_pkt_fifo.sv
// Store-and-forward RX packet FIFO: only complete good frames are released downstream.
// Define NETFPGA_SUME_10G_RX_FIFO_STATS_EN to build the pkt_count/drop_count counters.
module netfpga_sume_10g_rx_pkt_fifo
  import netfpga_sume_10g_pkg::*;
#(
  parameter int DEPTH_WORDS = 512
) (
  input  logic                   clk156,
  input  logic                   areset_clk156,
  input  logic [AXIS_DATA_W-1:0] s_axis_tdata,
  input  logic [AXIS_KEEP_W-1:0] s_axis_tkeep,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tuser,
  output logic [AXIS_DATA_W-1:0] m_axis_tdata,
  output logic [AXIS_KEEP_W-1:0] m_axis_tkeep,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready,
  output logic [31:0]            pkt_count,
  output logic [31:0]            drop_count
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PTR_ONE   = 1;

  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] wr_commit_q, wr_commit_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  wr_state_e       state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic            full, wr_en, rd_en;
  fifo_word_t      wr_word, rd_word;

  // Registered rd_ptr: space freed by a read only becomes usable next cycle.
  assign full    = (wr_ptr_q - rd_ptr_q) == DEPTH_CNT;
  assign wr_word = '{tlast: s_axis_tlast, tkeep: s_axis_tkeep, tdata: s_axis_tdata};

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    wr_en       = 1'b0;
    case (state_q)
      ST_IDLE, ST_WRITE: begin
        if (s_axis_tvalid) begin
          if (full) begin
            wr_ptr_d = wr_commit_q;
            state_d  = s_axis_tlast ? ST_IDLE : ST_DROP;
          end else begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            state_d  = ST_WRITE;
            if (s_axis_tlast) begin
              state_d = ST_IDLE;
              if (s_axis_tuser) wr_commit_d = wr_ptr_q + PTR_ONE;
              else              wr_ptr_d    = wr_commit_q;
            end
          end
        end
      end
      ST_DROP: begin
        if (s_axis_tvalid && s_axis_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The RAM read register doubles as the output register; a fetch refills it when empty or draining.
  assign rd_en = (rd_ptr_q != wr_commit_q) && (!out_valid_q || m_axis_tready);

  always_comb begin
    rd_ptr_d    = rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    out_valid_d = rd_en || (out_valid_q && !m_axis_tready);
  end

  always_ff @(posedge clk156 or posedge areset_clk156) begin
    if (areset_clk156) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
    end
  end

  netfpga_sume_sdp_ram #(
    .WIDTH (FIFO_WORD_W),
    .DEPTH (DEPTH_WORDS)
  ) u_ram (
    .clk_i   (clk156),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (wr_word),
    .re_i    (rd_en),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (rd_word)
  );

  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_valid_q ? rd_word.tdata : '0;
  assign m_axis_tkeep  = out_valid_q ? rd_word.tkeep : '0;
  assign m_axis_tlast  = out_valid_q && rd_word.tlast;

`ifdef NETFPGA_SUME_10G_RX_FIFO_STATS_EN
  logic        pkt_inc, drop_inc;
  logic [31:0] pkt_cnt_q, drop_cnt_q;

  // A frame is counted once: on its good tlast, on its bad tlast, or on the beat that found the FIFO full.
  assign pkt_inc  = s_axis_tvalid && (state_q != ST_DROP) && !full && s_axis_tlast && s_axis_tuser;
  assign drop_inc = s_axis_tvalid && (state_q != ST_DROP) && (full || (s_axis_tlast && !s_axis_tuser));

  always_ff @(posedge clk156 or posedge areset_clk156) begin
    if (areset_clk156) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (pkt_inc)  pkt_cnt_q  <= pkt_cnt_q + 32'd1;
      if (drop_inc) drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  assign pkt_count  = pkt_cnt_q;
  assign drop_count = drop_cnt_q;
`else
  assign pkt_count  = 32'd0;
  assign drop_count = 32'd0;
`endif

endmodule

// File: tb/tb_netfpga_sume_10g_rx_pkt_fifo.sv
// Self-checking bench for the RX packet FIFO: queue-based frame model, per-cycle output compare.
// Counter expectations follow NETFPGA_SUME_10G_RX_FIFO_STATS_EN (zero when undefined).
module tb_netfpga_sume_10g_rx_pkt_fifo;

  localparam int DEPTH = 16;

  logic        clk156 = 1'b0;
  logic        areset_clk156;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tvalid, s_axis_tlast, s_axis_tuser;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid, m_axis_tlast;
  logic        m_axis_tready;
  logic [31:0] pkt_count, drop_count;

  netfpga_sume_10g_rx_pkt_fifo #(.DEPTH_WORDS(DEPTH)) dut (
    .clk156        (clk156),
    .areset_clk156 (areset_clk156),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .pkt_count     (pkt_count),
    .drop_count    (drop_count)
  );

  always #5 clk156 = ~clk156;

  int cyc = 0;
  always @(posedge clk156) cyc <= cyc + 1;

  int          checks = 0;
  int          errors = 0;
  logic [72:0] exp_q[$];
  int          m_pkt = 0;
  int          m_drop = 0;
  int          rx_beats = 0;
  int          rdy_mode = 1;
  bit          lat_armed = 0;
  int          tlast_cyc = 0;
  bit          prev_stall = 0;
  logic [72:0] prev_beat;

  task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] expCount(input int v);
`ifdef NETFPGA_SUME_10G_RX_FIFO_STATS_EN
    return v;
`else
    return (v < 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  function automatic logic [7:0] keepBytes(input int n);
    logic [8:0] t;
    t = (9'd1 << n) - 9'd1;
    return t[7:0];
  endfunction

  // Beats held in RAM: everything not yet delivered, minus the one parked in the output stage.
  function automatic int storedBeats();
    return (exp_q.size() > 0) ? exp_q.size() - 1 : 0;
  endfunction

  // Downstream ready pattern: 0 = stalled, 1 = always ready, 2 = random 50%.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk156);
      #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b0;
        1:       m_axis_tready = 1'b1;
        default: m_axis_tready = ($urandom_range(1, 0) == 1);
      endcase
    end
  end

  task automatic sendBeat(input logic [63:0] d, input logic [7:0] k, input bit last, input bit user);
    @(posedge clk156);
    #1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = last;
    s_axis_tuser  = user;
  endtask

  task automatic applyStimulus(input int len, input bit good, input bit rnd,
                               input int lastBytes, input int gapPct, input bit arm);
    logic [72:0] beats[$];
    bit          accept;
    accept = good && ((len + storedBeats()) <= DEPTH);
    for (int i = 0; i < len; i++) begin
      logic [63:0] d;
      logic [7:0]  k;
      bit          last;
      last = (i == len - 1);
      d = rnd ? {$urandom, $urandom} : 64'(i + 1);
      k = last ? keepBytes((lastBytes == 0) ? $urandom_range(8, 1) : lastBytes) : 8'hFF;
      if (i > 0 && $urandom_range(99, 0) < gapPct) begin
        @(posedge clk156);
        #1;
        s_axis_tvalid = 1'b0;
      end
      sendBeat(d, k, last, last ? good : 1'b0);
      beats.push_back({last, k, d});
      if (last) begin
        if (arm) begin
          tlast_cyc = cyc;
          lat_armed = 1;
        end
        if (accept) begin
          foreach (beats[j]) exp_q.push_back(beats[j]);
          m_pkt++;
        end else begin
          m_drop++;
        end
      end
    end
    @(posedge clk156);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk156);
      n++;
    end
    checkOutput(name, exp_q.size(), 0);
    repeat (4) @(posedge clk156);
  endtask

  // Compare every delivered beat against the model, and check stalled beats stay put.
  always @(negedge clk156) begin
    logic [72:0] cur;
    cur = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
    if (areset_clk156) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) checkOutput("stall_hold", {m_axis_tvalid, cur}, {1'b1, prev_beat});
      if (m_axis_tvalid) begin
        if (lat_armed) begin
          checkOutput("latency", cyc - tlast_cyc, 2);
          lat_armed = 0;
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_beat actual=%0h required=none", cur);
        end else begin
          checkOutput("beat", cur, exp_q[0]);
          if (m_axis_tready) begin
            void'(exp_q.pop_front());
            rx_beats++;
          end
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = cur;
    end
  end

  initial begin
    areset_clk156 = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    repeat (3) @(posedge clk156);
    #1;
    checkOutput("rst_tvalid", m_axis_tvalid, 0);
    checkOutput("rst_tdata", m_axis_tdata, 0);
    checkOutput("rst_tkeep", m_axis_tkeep, 0);
    checkOutput("rst_tlast", m_axis_tlast, 0);
    checkOutput("rst_pkt", pkt_count, 0);
    checkOutput("rst_drop", drop_count, 0);
    areset_clk156 = 1'b0;
    repeat (2) @(posedge clk156);

    // 8-beat good frame, data 1..8, 4 bytes valid on the last beat
    rx_beats = 0;
    applyStimulus(8, 1, 0, 4, 0, 1);
    waitDrain("t1_drain", 100);
    checkOutput("t1_beats", rx_beats, 8);
    checkOutput("t1_pkt", pkt_count, expCount(1));
    checkOutput("t1_drop", drop_count, expCount(0));

    // Bad 6-beat frame followed by a good 3-beat frame
    rx_beats = 0;
    applyStimulus(6, 0, 1, 0, 0, 0);
    applyStimulus(3, 1, 1, 0, 0, 0);
    waitDrain("t2_drain", 100);
    checkOutput("t2_beats", rx_beats, 3);
    checkOutput("t2_pkt", pkt_count, expCount(2));
    checkOutput("t2_drop", drop_count, expCount(1));

    // Overflow with downstream stalled, then a frame arriving at a full FIFO
    rdy_mode = 0;
    repeat (2) @(posedge clk156);
    rx_beats = 0;
    applyStimulus(10, 1, 1, 0, 0, 0);
    applyStimulus(10, 1, 1, 0, 0, 0);
    checkOutput("t3_drop_b", drop_count, expCount(2));
    applyStimulus(7, 1, 1, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 0);
    repeat (5) @(posedge clk156);
    checkOutput("t3_pkt", pkt_count, expCount(4));
    checkOutput("t3_drop", drop_count, expCount(3));
    checkOutput("t3_stalled_valid", m_axis_tvalid, 1);
    rdy_mode = 1;
    waitDrain("t3_drain", 200);
    checkOutput("t3_beats", rx_beats, 17);

    // Random lengths and tuser under random backpressure
    rdy_mode = 2;
    for (int f = 0; f < 20; f++) begin
      int len;
      len = $urandom_range(64, 1);
      if (len == DEPTH) len = DEPTH - 1;
      applyStimulus(len, ($urandom_range(9, 0) != 0), 1, 0, 20, 0);
      waitDrain("t4_drain", 600);
    end
    checkOutput("t4_pkt", pkt_count, expCount(m_pkt));
    checkOutput("t4_drop", drop_count, expCount(m_drop));

    // Reset in the middle of a frame while a committed frame waits at the output
    rdy_mode = 0;
    repeat (2) @(posedge clk156);
    applyStimulus(2, 1, 1, 0, 0, 0);
    repeat (4) @(posedge clk156);
    #1;
    checkOutput("t5_pre_valid", m_axis_tvalid, 1);
    for (int i = 0; i < 3; i++) sendBeat({$urandom, $urandom}, 8'hFF, 1'b0, 1'b0);
    #2;
    areset_clk156 = 1'b1;
    #1;
    checkOutput("t5_rst_tvalid", m_axis_tvalid, 0);
    checkOutput("t5_rst_tdata", m_axis_tdata, 0);
    checkOutput("t5_rst_tkeep", m_axis_tkeep, 0);
    checkOutput("t5_rst_tlast", m_axis_tlast, 0);
    checkOutput("t5_rst_pkt", pkt_count, 0);
    exp_q.delete();
    m_pkt = 0;
    m_drop = 0;
    s_axis_tvalid = 1'b0;
    repeat (3) @(posedge clk156);
    #1;
    areset_clk156 = 1'b0;
    rdy_mode = 1;
    rx_beats = 0;
    applyStimulus(2, 1, 1, 0, 0, 0);
    waitDrain("t5_drain", 100);
    checkOutput("t5_beats", rx_beats, 2);
    checkOutput("t5_pkt", pkt_count, expCount(1));
    checkOutput("t5_drop", drop_count, expCount(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
